// File: rtl/seg_display_mux.sv
// seg_display_mux
// Time-multiplexed N-digit seven-segment driver with double-buffered updates.
// A load strobe captures a packed hex value and per-digit decimal points into
// a shadow buffer. The shadow is copied into the display register only at a
// frame boundary, so a scan never mixes old and new data. Each digit stays
// enabled for CLK_DIV clocks. Digit 0 is the rightmost digit.
//
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous, active-low reset
//   value     packed nibbles, nibble i drives digit i
//   dp        decimal point per digit, captured together with value
//   load      single-cycle capture strobe
//   blank_lz  leading-zero blanking enable (live, not buffered)
//   seg       registered segments, bit0=a .. bit6=g, bit7=dp
//   dig       registered one-hot digit enable
//   frame     one-cycle pulse on the first output cycle of digit 0 of a frame
//   pending   shadow holds data not yet shown on the display
//
// Load handshake: there is no backpressure. Every cycle with load=1 is
// accepted; a later load before the commit replaces the earlier one, and a
// load in the frame-boundary cycle is committed in that same cycle.
module seg_display_mux #(
  parameter int N_DIGITS   = 4,
  parameter int CLK_DIV    = 1000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   dp,
  input  logic                  load,
  input  logic                  blank_lz,
  output logic [7:0]            seg,
  output logic [N_DIGITS-1:0]   dig,
  output logic                  frame,
  output logic                  pending
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int IDX_W = $clog2(N_DIGITS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N_DIGITS - 1);
  // XOR masks: all ones inverts to active-low, all zeros keeps active-high.
  localparam logic [7:0]          SEG_OFF = {8{ACTIVE_LOW}};
  localparam logic [N_DIGITS-1:0] DIG_OFF = {N_DIGITS{ACTIVE_LOW}};

  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;
  logic                  tick;
  logic                  wrap;
  logic                  wrap_q;
  logic [4*N_DIGITS-1:0] shadow_val;
  logic [N_DIGITS-1:0]   shadow_dp;
  logic [4*N_DIGITS-1:0] disp_val;
  logic [N_DIGITS-1:0]   disp_dp;

  logic [N_DIGITS-1:0]   hi_zero;
  logic                  zero_run;
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  blank;
  logic [N_DIGITS-1:0]   onehot;
  logic [7:0]            seg_ah;
  logic [N_DIGITS-1:0]   dig_ah;

  assign tick = (cnt == CNT_MAX);
  assign wrap = tick && (idx == IDX_MAX);

  function automatic logic [6:0] font7(input logic [3:0] n);
    case (n)
      4'h0:    font7 = 7'h3F;
      4'h1:    font7 = 7'h06;
      4'h2:    font7 = 7'h5B;
      4'h3:    font7 = 7'h4F;
      4'h4:    font7 = 7'h66;
      4'h5:    font7 = 7'h6D;
      4'h6:    font7 = 7'h7D;
      4'h7:    font7 = 7'h07;
      4'h8:    font7 = 7'h7F;
      4'h9:    font7 = 7'h6F;
      4'hA:    font7 = 7'h77;
      4'hB:    font7 = 7'h7C;
      4'hC:    font7 = 7'h39;
      4'hD:    font7 = 7'h5E;
      4'hE:    font7 = 7'h79;
      default: font7 = 7'h71;
    endcase
  endfunction

  // Prescaler and scan index.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      idx <= '0;
    end else if (tick) begin
      cnt <= '0;
      idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Shadow buffer and frame-boundary commit. A load in the boundary cycle
  // bypasses the shadow so it reaches the display without a frame of delay.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_val <= '0;
      shadow_dp  <= '0;
      disp_val   <= '0;
      disp_dp    <= '0;
      pending    <= 1'b0;
    end else begin
      if (load) begin
        shadow_val <= value;
        shadow_dp  <= dp;
      end
      if (wrap && (pending || load)) begin
        disp_val <= load ? value : shadow_val;
        disp_dp  <= load ? dp    : shadow_dp;
        pending  <= 1'b0;
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

  // hi_zero[i] is set when display nibbles i..N_DIGITS-1 are all zero.
  always_comb begin
    hi_zero  = '0;
    zero_run = 1'b1;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      zero_run   = zero_run & (disp_val[4*i +: 4] == 4'h0);
      hi_zero[i] = zero_run;
    end
  end

  // Active-high segment/digit pattern for the digit at the current index.
  always_comb begin
    cur_nib = disp_val[{idx, 2'b00} +: 4];
    cur_dp  = disp_dp[idx];
    blank   = blank_lz && (idx != '0) && hi_zero[idx];
    onehot  = {{(N_DIGITS-1){1'b0}}, 1'b1} << idx;
    seg_ah  = {cur_dp, font7(cur_nib)};
    dig_ah  = onehot;
    if (blank) begin
      // A blanked digit still lights its decimal point if that bit is set.
      seg_ah = {cur_dp, 7'h00};
      dig_ah = cur_dp ? onehot : '0;
    end
  end

  // Registered outputs. frame is delayed twice so it lines up with the first
  // output cycle of digit 0, which appears one clock after idx wraps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg    <= SEG_OFF;
      dig    <= DIG_OFF;
      wrap_q <= 1'b0;
      frame  <= 1'b0;
    end else begin
      seg    <= seg_ah ^ SEG_OFF;
      dig    <= dig_ah ^ DIG_OFF;
      wrap_q <= wrap;
      frame  <= wrap_q;
    end
  end

endmodule

// File: tb/tb_seg_display_mux.sv
module tb_seg_display_mux;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp = '0;
  logic [7:0]  seg, seg2;
  logic [3:0]  dig, dig2;
  logic        frame, frame2, pending, pending2;

  // Expected frames: {blank_lz, dp[3:0], value[15:0]}
  logic [20:0] exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          ne = 1;          // number of the next rising edge since release
  logic [15:0] latest_val = '0;
  logic [3:0]  latest_dp = '0;
  logic        pend_m = 1'b0;
  logic        blz_next = 1'b0;
  logic        mon_en = 1'b1;
  logic        mon_busy = 1'b0;
  logic        push_en = 1'b1;
  logic [20:0] first_w = '0;
  logic [20:0] mw;
  logic [11:0] mes;
  logic [6:0]  font_tab[16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [15:0] masks[5] = '{16'hFFFF, 16'h0FFF, 16'h00FF, 16'h000F, 16'h0000};

  seg_display_mux #(.N_DIGITS(4), .CLK_DIV(4), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .reset(reset), .value(value), .dp(dp), .load(load),
    .blank_lz(blank_lz), .seg(seg), .dig(dig), .frame(frame), .pending(pending)
  );

  seg_display_mux #(.N_DIGITS(4), .CLK_DIV(4), .ACTIVE_LOW(1'b0)) dut_hi (
    .clk(clk), .reset(reset), .value(value), .dp(dp), .load(load),
    .blank_lz(blank_lz), .seg(seg2), .dig(dig2), .frame(frame2), .pending(pending2)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Active-high {seg[7:0], dig[3:0]} for digit d of a displayed frame.
  function automatic logic [11:0] exp_slot(input logic [20:0] w, input int d);
    logic [15:0] upper;
    logic        dpb;
    logic [3:0]  oh;
    logic        blank;
    upper = w[15:0] >> (4 * d);
    dpb   = w[16 + d];
    oh    = 4'b0001 << d;
    blank = w[20] && (d > 0) && (upper == 16'h0);
    if (blank) return {dpb, 7'h00, (dpb ? oh : 4'h0)};
    return {dpb, font_tab[upper[3:0]], oh};
  endfunction

  // One clock of stimulus. Expected frames are pushed on the first edge of
  // each frame: the frame shows the last value loaded at or before the wrap.
  task automatic cycle(input logic ld, input logic [15:0] v, input logic [3:0] d);
    logic [11:0] es;
    if (ne % 16 == 1) begin
      blank_lz = blz_next;
      if (ne == 1) first_w = {blz_next, 4'h0, 16'h0};
      else if (push_en) exp_q.push_back({blz_next, latest_dp, latest_val});
    end
    load = ld;
    value = v;
    dp = d;
    if (ld) begin
      latest_val = v;
      latest_dp = d;
      pend_m = (ne % 16 != 0);
    end else if (ne % 16 == 0) begin
      pend_m = 1'b0;
    end
    @(posedge clk);
    #1;
    load = 1'b0;
    chk("pending", pending, pend_m);
    chk("pending_hi", pending2, pend_m);
    if (ne <= 16) begin
      es = exp_slot(first_w, (ne - 1) / 4);
      chk("first_seg", seg, es[11:4] ^ 8'hFF);
      chk("first_dig", dig, es[3:0] ^ 4'hF);
      chk("first_frame", frame, 0);
    end
    ne++;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 16'h0, 4'h0);
  endtask

  task automatic to_phase(input int p);
    while (ne % 16 != p) cycle(1'b0, 16'h0, 4'h0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_seg"}, seg, 8'hFF);
    chk({tag, "_dig"}, dig, 4'hF);
    chk({tag, "_pending"}, pending, 0);
    chk({tag, "_frame"}, frame, 0);
    chk({tag, "_seg_hi"}, seg2, 8'h00);
    chk({tag, "_dig_hi"}, dig2, 4'h0);
  endtask

  // monitor: one expected frame per frame pulse, 16 output cycles each
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && frame) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", 1, 0);
        end else begin
          mw = exp_q.pop_front();
          mon_busy = 1'b1;
          for (int k = 0; k < 16; k++) begin
            if (k > 0) @(negedge clk);
            mes = exp_slot(mw, k / 4);
            chk("seg", seg, mes[11:4] ^ 8'hFF);
            chk("dig", dig, mes[3:0] ^ 4'hF);
            chk("seg_hi", seg2, mes[11:4]);
            chk("dig_hi", dig2, mes[3:0]);
            chk("frame", frame, (k == 0));
            chk("frame_hi", frame2, (k == 0));
          end
          mon_busy = 1'b0;
        end
      end
    end
  end

  // watchdog
  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    bad++;
    total++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int n;
    // reset held while clocking
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("rst");
    reset = 1'b1;
    ne = 1;
    idle(16);

    // deferred commit of a mid-frame load
    to_phase(5);
    cycle(1'b1, 16'h12AF, 4'h0);
    idle(20);

    // overwrite before wrap, then a load exactly on the wrap cycle
    to_phase(3);
    cycle(1'b1, 16'h1111, 4'h0);
    idle(4);
    cycle(1'b1, 16'h2222, 4'h0);
    to_phase(0);
    idle(1);
    to_phase(0);
    cycle(1'b1, 16'h3333, 4'h0);
    idle(16);

    // polarity pattern
    to_phase(7);
    cycle(1'b1, 16'h0008, 4'h0);
    idle(24);

    // leading-zero blanking
    blz_next = 1'b1;
    to_phase(2);
    cycle(1'b1, 16'h0005, 4'b0100);
    idle(32);
    cycle(1'b1, 16'h0000, 4'h0);
    idle(32);
    blz_next = 1'b0;

    // randomized loads, values with random leading zeros, random blanking
    repeat (200) begin
      if (ne % 16 == 0) blz_next = 1'($urandom_range(0, 1));
      cycle(($urandom_range(0, 5) == 0), 16'($urandom) & masks[$urandom_range(0, 4)],
            4'($urandom));
    end

    // let the scoreboard empty
    push_en = 1'b0;
    n = 0;
    while ((exp_q.size() != 0 || mon_busy) && n < 64) begin
      cycle(1'b0, 16'h0, 4'h0);
      n++;
    end
    chk("drain", (exp_q.size() != 0 || mon_busy), 0);
    mon_en = 1'b0;

    // asynchronous reset while a commit is pending in slot 2
    to_phase(10);
    cycle(1'b1, 16'h1234, 4'hF);
    #2;
    reset = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    ne = 1;
    latest_val = '0;
    latest_dp = '0;
    pend_m = 1'b0;
    idle(16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
